// File: rtl/axi_read_responder.sv
// axi_read_responder: AXI4 read-only slave serving single-beat-at-a-time bursts from a synchronous BRAM
module axi_read_responder #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [28:0]       araddr,
    input  logic [1:0]        arburst,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [3:0]        arid,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [3:0]        rid,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [31:0]       bram_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t              r_state;
    logic [26:0]         r_ptr;
    logic [7:0]          r_cnt;
    logic [7:0]          r_len;
    logic [1:0]          r_burst;
    logic [3:0]          r_id;
    logic                r_slv;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rlast;
    logic                r_rvalid;
    logic                r_bram_en;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [26:0]         w_ptr_n;
    logic                w_slv_n;
    logic                w_dec_n;
    logic                w_dec;

    // Next word pointer: the AR address when accepting, else advanced per burst type (mod 2^27)
    assign w_ptr_n = (r_state == IDLE) ? araddr[28:2] : ((r_burst == 2'b01) ? r_ptr + 27'd1 : r_ptr);
    assign w_slv_n = (r_state == IDLE) ? (arsize != 3'b010 || arburst[1]) : r_slv;
    assign w_dec_n = (w_ptr_n >> ADDR_W) != 27'd0;
    assign w_dec   = (r_ptr >> ADDR_W) != 27'd0;

    assign arready   = (r_state == IDLE);
    assign rdata     = r_rdata;
    assign rid       = r_id;
    assign rresp     = r_rresp;
    assign rlast     = r_rlast;
    assign rvalid    = r_rvalid;
    assign bram_en   = r_bram_en;
    assign bram_addr = r_bram_addr;

    // Transaction FSM: IDLE -> ISSUE (BRAM read) -> WAIT (BRAM latency) -> RESP (hold beat until rready)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_burst     <= '0;
            r_id        <= '0;
            r_slv       <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= '0;
            r_rlast     <= 1'b0;
            r_rvalid    <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
        end else begin
            case (r_state)
                IDLE: if (arvalid) begin
                    r_id        <= arid;
                    r_len       <= arlen;
                    r_burst     <= arburst;
                    r_slv       <= w_slv_n;
                    r_ptr       <= w_ptr_n;
                    r_cnt       <= '0;
                    r_bram_en   <= !(w_slv_n || w_dec_n);
                    r_bram_addr <= w_ptr_n[ADDR_W-1:0];
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    r_bram_en <= 1'b0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    r_rdata  <= (r_slv || w_dec) ? 32'd0 : bram_rdata;
                    r_rresp  <= r_slv ? 2'b10 : (w_dec ? 2'b11 : 2'b00);
                    r_rlast  <= (r_cnt == r_len);
                    r_rvalid <= 1'b1;
                    r_state  <= RESP;
                end
                RESP: if (rready) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                    if (r_rlast) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt       <= r_cnt + 8'd1;
                        r_ptr       <= w_ptr_n;
                        r_bram_en   <= !(w_slv_n || w_dec_n);
                        r_bram_addr <= w_ptr_n[ADDR_W-1:0];
                        r_state     <= ISSUE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder: directed and randomized read bursts checked against a per-beat reference model
module tb_axi_read_responder;
    localparam int AW = 12;
    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [28:0]   araddr = '0;
    logic [1:0]    arburst = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [3:0]    arid = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [3:0]    rid;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_rdata = '0;
    logic [31:0]   mem [0:4095];
    int            checks = 0;
    int            errors = 0;
    int            en_cnt = 0;

    axi_read_responder #(.ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .araddr(araddr), .arburst(arburst), .arlen(arlen),
        .arsize(arsize), .arid(arid), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM model plus a count of read enables
    always @(posedge clk) begin
        if (bram_en) begin
            bram_rdata <= mem[bram_addr];
            en_cnt     <= en_cnt + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] mptr(input logic [28:0] a, input logic [1:0] b, input int i);
        return (b == 2'b01) ? 27'(a[28:2] + 27'(i)) : a[28:2];
    endfunction

    function automatic logic [1:0] mresp(input logic [28:0] a, input logic [1:0] b, input logic [2:0] s, input int i);
        if (s != 3'd2 || b >= 2'd2) return 2'b10;
        if (mptr(a, b, i) >= 27'd4096) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] mdata(input logic [28:0] a, input logic [1:0] b, input logic [2:0] s, input int i);
        logic [26:0] p;
        p = mptr(a, b, i);
        return (mresp(a, b, s, i) != 2'b00) ? 32'd0 : mem[p[11:0]];
    endfunction

    task automatic issue(input logic [28:0] a, input logic [1:0] b, input logic [7:0] l,
                         input logic [2:0] s, input logic [3:0] id);
        int n;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ar_wait", arready, 1);
        araddr = a; arburst = b; arlen = l; arsize = s; arid = id; arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic wait_rvalid();
        int n;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_wait", rvalid, 1);
    endtask

    // Drive rready for every beat of an accepted burst; stall < 0 picks a random stall per beat
    task automatic beats(input logic [28:0] a, input logic [1:0] b, input logic [7:0] l,
                         input logic [2:0] s, input logic [3:0] id, input int stall);
        int e0, ok, lat, st;
        logic [1:0]  er;
        logic [31:0] ed;
        e0 = en_cnt;
        ok = 0;
        for (int i = 0; i <= int'(l); i++) begin
            er = mresp(a, b, s, i);
            ed = mdata(a, b, s, i);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!rvalid && lat < 20);
            chk("r_latency", lat, 3);
            if (!rvalid) return;
            if (er == 2'b00) ok++;
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int c = 0; c <= st; c++) begin
                if (c > 0) @(negedge clk);
                chk("rvalid", rvalid, 1);
                chk("rdata", rdata, ed);
                chk("rid", rid, id);
                chk("rresp", rresp, er);
                chk("rlast", rlast, i == int'(l));
            end
            rready = 1'b1;
            @(posedge clk);
            #1 rready = 1'b0;
        end
        @(negedge clk);
        chk("arready_after_last", arready, 1);
        chk("rvalid_after_last", rvalid, 0);
        chk("bram_en_count", en_cnt - e0, ok);
    endtask

    initial begin
        logic [28:0] a;
        logic [1:0]  b;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [3:0]  id;
        int          r;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;
        #3;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_addr", bram_addr, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_arready", arready, 1);

        issue(29'h14, 2'b01, 8'd0, 3'd2, 4'd3);
        beats(29'h14, 2'b01, 8'd0, 3'd2, 4'd3, 0);
        issue(29'h0, 2'b01, 8'd3, 3'd2, 4'd1);
        beats(29'h0, 2'b01, 8'd3, 3'd2, 4'd1, 0);
        issue(29'h8, 2'b00, 8'd2, 3'd2, 4'd5);
        beats(29'h8, 2'b00, 8'd2, 3'd2, 4'd5, 5);
        issue(29'h4000, 2'b01, 8'd0, 3'd2, 4'd6);
        beats(29'h4000, 2'b01, 8'd0, 3'd2, 4'd6, 0);
        issue(29'h100, 2'b01, 8'd2, 3'd3, 4'd7);
        beats(29'h100, 2'b01, 8'd2, 3'd3, 4'd7, 0);
        issue(29'h3FFC, 2'b01, 8'd1, 3'd2, 4'd8);
        beats(29'h3FFC, 2'b01, 8'd1, 3'd2, 4'd8, 0);
        issue(29'h10, 2'b10, 8'd1, 3'd2, 4'd9);
        beats(29'h10, 2'b10, 8'd1, 3'd2, 4'd9, 1);
        issue(29'h1FFFFFFE, 2'b01, 8'd1, 3'd2, 4'd2);
        beats(29'h1FFFFFFE, 2'b01, 8'd1, 3'd2, 4'd2, 0);

        issue(29'h40, 2'b01, 8'd7, 3'd2, 4'd4);
        wait_rvalid();
        chk("mid_beat1", rdata, mdata(29'h40, 2'b01, 3'd2, 0));
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        wait_rvalid();
        chk("mid_beat2", rdata, mdata(29'h40, 2'b01, 3'd2, 1));
        #2 rstn = 1'b0;
        #1;
        chk("async_rvalid", rvalid, 0);
        chk("async_rdata", rdata, 0);
        chk("async_rid", rid, 0);
        chk("async_rlast", rlast, 0);
        chk("async_bram_en", bram_en, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_arready", arready, 1);
            chk("post_rst_rvalid", rvalid, 0);
        end
        issue(29'h7C, 2'b01, 8'd2, 3'd2, 4'hE);
        beats(29'h7C, 2'b01, 8'd2, 3'd2, 4'hE, 1);

        issue(29'h20, 2'b01, 8'd2, 3'd2, 4'hA);
        araddr = 29'h204; arburst = 2'b01; arlen = 8'd1; arsize = 3'd2; arid = 4'hC; arvalid = 1'b1;
        beats(29'h20, 2'b01, 8'd2, 3'd2, 4'hA, 0);
        @(posedge clk);
        #1 arvalid = 1'b0;
        beats(29'h204, 2'b01, 8'd1, 3'd2, 4'hC, 0);

        repeat (16) begin
            r = int'($urandom_range(0, 9));
            a = (r < 7) ? {16'd0, 11'($urandom_range(0, 4000)), 2'($urandom)}
                        : {16'd0, 11'd0, 2'd0} + 29'(($urandom_range(4088, 4100) << 2) | $urandom_range(0, 3));
            if (r == 9) a = 29'($urandom);
            r = int'($urandom_range(0, 9));
            b = (r < 7) ? 2'b01 : (r < 9) ? 2'b00 : 2'($urandom);
            s = ($urandom_range(0, 9) < 9) ? 3'd2 : 3'($urandom);
            l = 8'($urandom_range(0, 5));
            id = 4'($urandom);
            issue(a, b, l, s, id);
            beats(a, b, l, s, id, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
